cadence_sched: RTL and testbench
================================

CADENCE_SCHED -- requirements
Module: cadence_sched

Interface
REQ-001 SHALL have parameter FAST_SIM, default 1, meaning shorten the tick prescaler for simulation (1: 16 clk/tick; 0: 1024 clk/tick).
REQ-002 SHALL have port clk  input  1  system clock; every flop is rising-edge triggered.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cadence_rise  input  1  single-cycle pulse marking a filtered pedal-sensor rising edge.
REQ-005 SHALL have port cadence_per  output  8  last measured pedal period, in ticks.
REQ-006 SHALL have port per_vld  output  1  single-cycle strobe when cadence_per updates.
REQ-007 SHALL have port include_smpl  output  1  single-cycle strobe to downstream torque/power accumulation.
REQ-008 SHALL have port not_pedaling  output  1  high while in STOPPED.
REQ-009 SHALL have port state  output  2  current FSM state (STOPPED=00, SYNC=01, RUN=10), for debug.

Function
REQ-010 SHALL contain a prescaler P = 16 (FAST_SIM=1) or 1024 (FAST_SIM=0) that counts 0..P-1 and wraps.
REQ-011 SHALL assert an internal tick for one cycle when the prescaler equals P-1.
REQ-012 SHALL clear the prescaler to 0 on the cycle after any cadence_rise, so the first post-rise tick occurs P cycles after the rise.
REQ-013 SHALL contain an 8-bit period counter cnt that increments on each tick and saturates at 0xFF.
REQ-014 SHALL clear cnt to 0 on any cadence_rise.
REQ-015 SHALL exclude a tick coincident with cadence_rise from the latched period.
REQ-016 STOPPED: SHALL drive not_pedaling=1 and, on cadence_rise, go to SYNC; cadence_per holds.
REQ-017 SYNC: on cadence_rise, SHALL latch cnt into cadence_per, pulse per_vld, and go to RUN; include_smpl stays 0.
REQ-018 SYNC: on a tick with cnt==0xFF and no rise, SHALL go to STOPPED with cadence_per unchanged.
REQ-019 RUN: on cadence_rise, SHALL latch cnt into cadence_per, pulse per_vld and include_smpl in the same cycle, and stay in RUN.
REQ-020 RUN: on a tick with cnt==0xFF and no rise, SHALL load cadence_per=0xFF, pulse per_vld, and go to STOPPED.
REQ-021 SHALL give cadence_rise priority over saturation when both occur in the same cycle.
REQ-022 SHALL register all outputs; strobes appear the cycle after the causing cadence_rise or tick.
REQ-023 SHALL never assert per_vld or include_smpl for more than one consecutive cycle unless cadence_rise is asserted on consecutive cycles.
REQ-024 SHALL map unused state encoding 11 to STOPPED on the next clock.

Reset
REQ-025 On rst_n low, SHALL immediately set: state=STOPPED, not_pedaling=1, cadence_per=0xFF, per_vld=0, include_smpl=0, cnt=0, prescaler=0.
REQ-026 Reset asserted mid-RUN SHALL abort any pending measurement; the first rise after release SHALL enter SYNC and SHALL NOT produce per_vld.

Verification (FAST_SIM=1, P=16)
REQ-027 Reset release, no rises for 5000 clk -> state=STOPPED, not_pedaling=1, cadence_per=0xFF, no strobes.
REQ-028 Rises at t=0 and t=168 -> SYNC after the first rise; at t=169, cadence_per=10, per_vld=1 for one cycle, include_smpl=0, state=RUN.
REQ-029 Continue from REQ-028 with further rises every 168 clk -> each rise gives cadence_per=10, with per_vld and include_smpl both pulsing once.
REQ-030 In RUN, stop rises for 256*16+2 clk -> one per_vld with cadence_per=0xFF, state=STOPPED, not_pedaling=1.
REQ-031 In RUN, a rise coincident with the saturating tick -> state stays RUN, cadence_per=0xFF, include_smpl pulses.
REQ-032 rst_n pulsed low in RUN, then rises 168 clk apart -> first rise gives SYNC with no strobe; second gives cadence_per=10.

Source files
------------

// File: rtl/cadence_sched.sv
// Pedal cadence scheduler: measures the pedal period in prescaled ticks and
// tells downstream torque/power logic when a full revolution sample is valid.
module cadence_sched #(
    parameter bit FAST_SIM = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cadence_rise,
    output logic [7:0] cadence_per,
    output logic       per_vld,
    output logic       include_smpl,
    output logic       not_pedaling,
    output logic [1:0] state
);

    localparam logic [9:0] PRESC_MAX = FAST_SIM ? 10'd15 : 10'd1023;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_SYNC    = 2'b01,
        ST_RUN     = 2'b10
    } state_t;

    state_t     state_r;
    state_t     state_nxt_s;
    logic [9:0] presc_r;
    logic [7:0] cnt_r;
    logic [7:0] cadence_per_r;
    logic       per_vld_r;
    logic       include_smpl_r;
    logic       not_pedaling_r;
    logic       tick_s;
    logic       sat_s;
    logic [7:0] per_nxt_s;
    logic       per_vld_nxt_s;
    logic       incl_nxt_s;

    assign tick_s = (presc_r == PRESC_MAX);
    // Saturation only fires on the tick that would push cnt past 0xFF.
    assign sat_s  = tick_s && (cnt_r == 8'hFF);

    // Prescaler: restarts on every rise so the period is phase-aligned to the pedal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= 10'd0;
        end else if (cadence_rise || tick_s) begin
            presc_r <= 10'd0;
        end else begin
            presc_r <= presc_r + 10'd1;
        end
    end

    // Period counter in ticks, saturating; a rise wins over a coincident tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= 8'd0;
        end else if (cadence_rise) begin
            cnt_r <= 8'd0;
        end else if (tick_s && (cnt_r != 8'hFF)) begin
            cnt_r <= cnt_r + 8'd1;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_STOPPED;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and next-output logic; cadence_rise takes priority over saturation.
    always_comb begin
        state_nxt_s   = state_r;
        per_nxt_s     = cadence_per_r;
        per_vld_nxt_s = 1'b0;
        incl_nxt_s    = 1'b0;
        case (state_r)
            ST_STOPPED: begin
                if (cadence_rise) begin
                    state_nxt_s = ST_SYNC;
                end else begin
                    state_nxt_s = ST_STOPPED;
                end
            end
            ST_SYNC: begin
                if (cadence_rise) begin
                    per_nxt_s     = cnt_r;
                    per_vld_nxt_s = 1'b1;
                    state_nxt_s   = ST_RUN;
                end else if (sat_s) begin
                    state_nxt_s = ST_STOPPED;
                end else begin
                    state_nxt_s = ST_SYNC;
                end
            end
            ST_RUN: begin
                if (cadence_rise) begin
                    per_nxt_s     = cnt_r;
                    per_vld_nxt_s = 1'b1;
                    incl_nxt_s    = 1'b1;
                    state_nxt_s   = ST_RUN;
                end else if (sat_s) begin
                    per_nxt_s     = 8'hFF;
                    per_vld_nxt_s = 1'b1;
                    state_nxt_s   = ST_STOPPED;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_STOPPED;
            end
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cadence_per_r  <= 8'hFF;
            per_vld_r      <= 1'b0;
            include_smpl_r <= 1'b0;
            not_pedaling_r <= 1'b1;
        end else begin
            cadence_per_r  <= per_nxt_s;
            per_vld_r      <= per_vld_nxt_s;
            include_smpl_r <= incl_nxt_s;
            not_pedaling_r <= (state_nxt_s == ST_STOPPED);
        end
    end

    assign cadence_per  = cadence_per_r;
    assign per_vld      = per_vld_r;
    assign include_smpl = include_smpl_r;
    assign not_pedaling = not_pedaling_r;
    assign state        = state_r;

endmodule

// File: tb/tb_cadence_sched.sv
// Scoreboard bench for cadence_sched (FAST_SIM=1, 16 clk per tick).
module tb_cadence_sched;

    logic       clk;
    logic       rst_n;
    logic       cadence_rise;
    logic [7:0] cadence_per;
    logic       per_vld;
    logic       include_smpl;
    logic       not_pedaling;
    logic [1:0] state;

    typedef struct {
        logic [7:0] per;
        logic       incl;
        logic [1:0] st;
    } strobe_t;

    typedef struct {
        string      name;
        logic [1:0] st;
        logic       np;
        logic [7:0] per;
    } status_t;

    strobe_t exp_q[$];
    status_t stat_q[$];
    int      checks;
    int      errors;
    bit      done;

    cadence_sched #(.FAST_SIM(1'b1)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cadence_rise (cadence_rise),
        .cadence_per  (cadence_per),
        .per_vld      (per_vld),
        .include_smpl (include_smpl),
        .not_pedaling (not_pedaling),
        .state        (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic rise_after(input int gap);
        repeat (gap - 1) @(negedge clk);
        cadence_rise = 1'b1;
        @(negedge clk);
        cadence_rise = 1'b0;
    endtask

    task automatic exp_strobe(input logic [7:0] per, input logic incl, input logic [1:0] st);
        strobe_t e;
        e.per  = per;
        e.incl = incl;
        e.st   = st;
        exp_q.push_back(e);
    endtask

    task automatic exp_status(input string name, input logic [1:0] st, input logic np,
                              input logic [7:0] per);
        status_t s;
        s.name = name;
        s.st   = st;
        s.np   = np;
        s.per  = per;
        stat_q.push_back(s);
    endtask

    // Stimulus
    initial begin
        done         = 1'b0;
        rst_n        = 1'b0;
        cadence_rise = 1'b0;
        repeat (3) @(negedge clk);
        exp_status("reset", 2'b00, 1'b1, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        repeat (5000) @(negedge clk);
        exp_status("idle_5000", 2'b00, 1'b1, 8'hFF);

        rise_after(1);
        exp_status("first_rise_sync", 2'b01, 1'b0, 8'hFF);
        exp_strobe(8'd10, 1'b0, 2'b10);
        rise_after(168);
        exp_status("sync_to_run", 2'b10, 1'b0, 8'd10);

        for (int i = 0; i < 3; i++) begin
            exp_strobe(8'd10, 1'b1, 2'b10);
            rise_after(168);
        end
        exp_strobe(8'd2, 1'b1, 2'b10);
        rise_after(40);
        exp_strobe(8'd0, 1'b1, 2'b10);
        rise_after(16);
        exp_strobe(8'd1, 1'b1, 2'b10);
        rise_after(17);
        exp_strobe(8'h12, 1'b1, 2'b10);
        rise_after(300);

        exp_strobe(8'hFF, 1'b0, 2'b00);
        repeat (256 * 16 + 2) @(negedge clk);
        exp_status("run_timeout", 2'b00, 1'b1, 8'hFF);

        rise_after(1);
        exp_status("resync", 2'b01, 1'b0, 8'hFF);
        exp_strobe(8'd10, 1'b0, 2'b10);
        rise_after(168);
        exp_strobe(8'hFF, 1'b1, 2'b10);
        rise_after(4096);
        exp_status("rise_beats_sat", 2'b10, 1'b0, 8'hFF);

        repeat (50) @(negedge clk);
        #3 rst_n = 1'b0;
        @(negedge clk);
        exp_status("reset_mid_run", 2'b00, 1'b1, 8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (100) @(negedge clk);
        rise_after(1);
        exp_status("post_reset_sync", 2'b01, 1'b0, 8'hFF);
        exp_strobe(8'd10, 1'b0, 2'b10);
        rise_after(168);
        exp_status("post_reset_run", 2'b10, 1'b0, 8'd10);

        exp_strobe(8'hFF, 1'b0, 2'b00);
        repeat (4100) @(negedge clk);
        rise_after(1);
        exp_status("sync_again", 2'b01, 1'b0, 8'hFF);
        repeat (4100) @(negedge clk);
        exp_status("sync_timeout", 2'b00, 1'b1, 8'hFF);

        repeat (5) @(negedge clk);
        done = 1'b1;
    end

    // Monitor: scores every strobe and every status probe, then reports.
    initial begin
        strobe_t e;
        status_t s;
        checks = 0;
        errors = 0;
        while (!done) begin
            @(negedge clk);
            if (per_vld || include_smpl) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL strobe: got per_vld=%0b include_smpl=%0b cadence_per=%0h, required no strobe",
                             per_vld, include_smpl, cadence_per);
                end else begin
                    e = exp_q.pop_front();
                    if (per_vld !== 1'b1 || cadence_per !== e.per || include_smpl !== e.incl || state !== e.st) begin
                        errors++;
                        $display("FAIL strobe: got vld=%0b per=%0h incl=%0b state=%0d, required vld=1 per=%0h incl=%0b state=%0d",
                                 per_vld, cadence_per, include_smpl, state, e.per, e.incl, e.st);
                    end
                end
            end
            while (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                checks++;
                if (state !== s.st || not_pedaling !== s.np || cadence_per !== s.per) begin
                    errors++;
                    $display("FAIL %s: got state=%0d not_pedaling=%0b per=%0h, required state=%0d not_pedaling=%0b per=%0h",
                             s.name, state, not_pedaling, cadence_per, s.st, s.np, s.per);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL missing_strobes: got %0d outstanding, required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
